apb_manager: RTL and testbench

APB_MANAGER -- requirements
Module: apb_manager

---
 rtl/apb_pkg.sv | 31 +++
 rtl/apb_manager_if.sv | 42 ++++
 rtl/apb_slave.sv | 39 +++
 rtl/apb_manager.sv | 113 +++++++++++
 tb/tb_apb_manager.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// apb_pkg -- shared definitions for the APB manager slice.
//   apb_state_e     : manager FSM states (IDLE, SETUP, ACCESS)
//   APB_NUM_SLAVES  : number of slaves decoded by the manager
//   APB_BASE_ADDR   : first byte of the slave window
//   APB_SLAVE_STRIDE: bytes per slave (selected by addr[13:12])
//   slave_onehot()  : slave index -> one-hot PSEL vector
//   addr_in_window(): true when an address lands in the slave window
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int          APB_NUM_SLAVES   = 4;
  localparam int          APB_SEL_W        = 2;
  localparam logic [31:0] APB_BASE_ADDR    = 32'h1000_0000;
  localparam logic [31:0] APB_SLAVE_STRIDE = 32'h0000_1000;
  localparam logic [31:0] APB_WINDOW       = 32'(APB_NUM_SLAVES) * APB_SLAVE_STRIDE;

  function automatic logic [APB_NUM_SLAVES-1:0] slave_onehot(input logic [APB_SEL_W-1:0] idx);
    slave_onehot      = '0;
    slave_onehot[idx] = 1'b1;
  endfunction

  function automatic logic addr_in_window(input logic [31:0] addr);
    addr_in_window = (addr >= APB_BASE_ADDR) && (addr < APB_BASE_ADDR + APB_WINDOW);
  endfunction

endpackage

// File: rtl/apb_manager_if.sv
// apb_manager_if -- request side plus APB bus of the manager.
//   request : transfer/write/addr/wdata in, rdata/ready back
//   APB     : PADDR, PWRITE, PENABLE, PWDATA, PSEL0..3 out;
//             PRDATA0..3, PREADY0..3 back from the slaves
//   modport master : view of apb_manager
//   modport slave  : view of whatever sits around the manager
interface apb_manager_if;

  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  logic [3:0]  PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic        PSEL0, PSEL1, PSEL2, PSEL3;
  logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
  logic        PREADY0, PREADY1, PREADY2, PREADY3;

  modport master (
    input  transfer, write, addr, wdata,
    output rdata, ready,
    output PADDR, PWRITE, PENABLE, PWDATA,
    output PSEL0, PSEL1, PSEL2, PSEL3,
    input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
    input  PREADY0, PREADY1, PREADY2, PREADY3
  );

  modport slave (
    output transfer, write, addr, wdata,
    input  rdata, ready,
    input  PADDR, PWRITE, PENABLE, PWDATA,
    input  PSEL0, PSEL1, PSEL2, PSEL3,
    output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
    output PREADY0, PREADY1, PREADY2, PREADY3
  );

endinterface

// File: rtl/apb_slave.sv
// apb_slave -- zero-wait-state APB register peripheral.
//   PCLK, PRESET        : clock, synchronous active-high reset
//   PADDR[3:2]          : register index (four 32-bit registers)
//   PSEL/PENABLE/PWRITE : write lands on the edge where all three are 1
//   PWDATA              : write data
//   PRDATA              : selected register during a read access, else 0
//   PREADY              : PSEL & PENABLE (never stalls)
module apb_slave (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY
);

  logic [3:0][31:0] regs;
  logic             acc;

  assign acc = PSEL & PENABLE;

  always_ff @(posedge PCLK) begin
    if (PRESET)
      regs <= '0;
    else if (acc && PWRITE)
      regs[PADDR[3:2]] <= PWDATA;
  end

  assign PREADY = acc;
  assign PRDATA = (acc && !PWRITE) ? regs[PADDR[3:2]] : 32'h0;

  // Byte lane bits carry no meaning for word registers.
  logic unused_paddr;
  assign unused_paddr = ^PADDR[1:0];

endmodule

// File: rtl/apb_manager.sv
// apb_manager -- single-outstanding APB manager for four slaves.
//   PCLK, PRESET : clock, synchronous active-high reset
//   bus          : apb_manager_if.master
//                  transfer strobe accepted in IDLE only; addr/write/wdata
//                  latched then, driven as PADDR/PWRITE/PWDATA until done.
//                  PSELx from addr[13:12]; ready/rdata follow the selected
//                  slave combinationally during ACCESS.
// Build option: APB_ADDR_CHECK_EN -- addresses outside the slave window
//   run SETUP/ACCESS with no PSEL and complete at once with rdata=0.
//   Undefined: addr[31:14] ignored, every address aliases onto a slave.
module apb_manager
  import apb_pkg::*;
(
  input  logic          PCLK,
  input  logic          PRESET,
  apb_manager_if.master bus
);

  localparam int NS = APB_NUM_SLAVES;

  apb_state_e             state_q;
  logic [3:0]             paddr_q;
  logic                   pwrite_q;
  logic [31:0]            pwdata_q;
  logic                   penable_q;
  logic [NS-1:0]          psel_q;
  logic [APB_SEL_W-1:0]   sel_q;
  logic                   err_q;

  logic [NS-1:0][31:0]    prdata_v;
  logic [NS-1:0]          pready_v;
  logic                   addr_err;
  logic [NS-1:0]          sel_dec;
  logic                   sel_ready;
  logic                   in_access;

  assign prdata_v = {bus.PRDATA3, bus.PRDATA2, bus.PRDATA1, bus.PRDATA0};
  assign pready_v = {bus.PREADY3, bus.PREADY2, bus.PREADY1, bus.PREADY0};

`ifdef APB_ADDR_CHECK_EN
  assign addr_err = !addr_in_window(bus.addr);
`else
  assign addr_err = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{bus.addr[31:14], bus.addr[11:4]};
`endif

  // An out-of-window request still walks the bus phases but selects nobody.
  assign sel_dec   = addr_err ? '0 : slave_onehot(bus.addr[13:12]);

  // No slave behind an errored request, so nothing can stall it.
  assign sel_ready = err_q ? 1'b1 : pready_v[sel_q];
  assign in_access = (state_q == ACCESS);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      sel_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.transfer) begin
            state_q  <= SETUP;
            paddr_q  <= bus.addr[3:0];
            pwrite_q <= bus.write;
            pwdata_q <= bus.wdata;
            sel_q    <= bus.addr[13:12];
            err_q    <= addr_err;
            psel_q   <= sel_dec;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // Latched request is dropped on completion so the bus reads
          // all-zero whenever the manager is idle.
          if (sel_ready) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            penable_q <= 1'b0;
            psel_q    <= '0;
            sel_q     <= '0;
            err_q     <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.PADDR   = paddr_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PENABLE = penable_q;
  assign bus.PSEL0   = psel_q[0];
  assign bus.PSEL1   = psel_q[1];
  assign bus.PSEL2   = psel_q[2];
  assign bus.PSEL3   = psel_q[3];

  assign bus.ready = in_access & sel_ready;
  assign bus.rdata = (in_access && !pwrite_q && !err_q) ? prdata_v[sel_q] : 32'h0;

endmodule

// File: tb/tb_apb_manager.sv
// tb_apb_manager -- manager plus four apb_slave peripherals, directed
// scenarios followed by randomized traffic against a register-map model.
module tb_apb_manager;

  logic PCLK = 1'b0;
  logic PRESET;
  logic stall;

  always #5 PCLK = ~PCLK;

  apb_manager_if bus ();

  apb_manager dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus.master));

  logic [31:0] s_prdata [4];
  logic [3:0]  s_pready;

  apb_slave s0 (.PCLK(PCLK), .PRESET(PRESET), .PADDR(bus.PADDR), .PWRITE(bus.PWRITE),
                .PSEL(bus.PSEL0), .PENABLE(bus.PENABLE), .PWDATA(bus.PWDATA),
                .PRDATA(s_prdata[0]), .PREADY(s_pready[0]));
  apb_slave s1 (.PCLK(PCLK), .PRESET(PRESET), .PADDR(bus.PADDR), .PWRITE(bus.PWRITE),
                .PSEL(bus.PSEL1), .PENABLE(bus.PENABLE), .PWDATA(bus.PWDATA),
                .PRDATA(s_prdata[1]), .PREADY(s_pready[1]));
  apb_slave s2 (.PCLK(PCLK), .PRESET(PRESET), .PADDR(bus.PADDR), .PWRITE(bus.PWRITE),
                .PSEL(bus.PSEL2), .PENABLE(bus.PENABLE), .PWDATA(bus.PWDATA),
                .PRDATA(s_prdata[2]), .PREADY(s_pready[2]));
  apb_slave s3 (.PCLK(PCLK), .PRESET(PRESET), .PADDR(bus.PADDR), .PWRITE(bus.PWRITE),
                .PSEL(bus.PSEL3), .PENABLE(bus.PENABLE), .PWDATA(bus.PWDATA),
                .PRDATA(s_prdata[3]), .PREADY(s_pready[3]));

  // stall masks every slave's PREADY to create wait states.
  assign bus.PRDATA0 = s_prdata[0];
  assign bus.PRDATA1 = s_prdata[1];
  assign bus.PRDATA2 = s_prdata[2];
  assign bus.PRDATA3 = s_prdata[3];
  assign bus.PREADY0 = s_pready[0] & ~stall;
  assign bus.PREADY1 = s_pready[1] & ~stall;
  assign bus.PREADY2 = s_pready[2] & ~stall;
  assign bus.PREADY3 = s_pready[3] & ~stall;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference register map: mem[slave][word].
  logic [31:0] mem [4][4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
`ifdef APB_ADDR_CHECK_EN
    return (a < 32'h1000_0000) || (a > 32'h1000_3FFF);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] slv_reg(input int k, input int r);
    case (k)
      0:       return s0.regs[r];
      1:       return s1.regs[r];
      2:       return s2.regs[r];
      default: return s3.regs[r];
    endcase
  endfunction

  function automatic logic [3:0] psel_vec();
    return {bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_psel"},    {28'h0, psel_vec()}, 32'h0);
    chk({tag, "_penable"}, {31'h0, bus.PENABLE}, 32'h0);
    chk({tag, "_ready"},   {31'h0, bus.ready}, 32'h0);
    chk({tag, "_rdata"},   bus.rdata, 32'h0);
    chk({tag, "_paddr"},   {28'h0, bus.PADDR}, 32'h0);
    chk({tag, "_pwrite"},  {31'h0, bus.PWRITE}, 32'h0);
    chk({tag, "_pwdata"},  bus.PWDATA, 32'h0);
  endtask

  task automatic chk_regs(input string tag);
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 4; r++)
        chk($sformatf("%s_s%0d_r%0d", tag, k, r), slv_reg(k, r), mem[k][r]);
  endtask

  // Called at an IDLE-cycle negedge; returns at the next IDLE-cycle negedge.
  // Request inputs are scrambled (and transfer re-pulsed) while busy so that
  // latching and the ignore-while-busy rule are exercised on every transfer.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input int stall_n, output logic [31:0] rd);
    logic        err;
    int          s, r, ns;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rd;
    err     = addr_bad(a);
    s       = int'(a[13:12]);
    r       = int'(a[3:2]);
    ns      = err ? 0 : stall_n;
    exp_sel = err ? 4'b0 : (4'b0001 << s);
    exp_rd  = (!wr && !err) ? mem[s][r] : 32'h0;
    rd      = 32'h0;

    chk_idle("idle");
    bus.transfer = 1'b1;
    bus.write    = wr;
    bus.addr     = a;
    bus.wdata    = d;

    @(negedge PCLK);  // SETUP
    bus.transfer = 1'($urandom_range(0, 1));
    bus.write    = 1'($urandom);
    bus.addr     = $urandom;
    bus.wdata    = $urandom;
    stall        = (ns > 0);
    chk("setup_psel",    {28'h0, psel_vec()}, {28'h0, exp_sel});
    chk("setup_penable", {31'h0, bus.PENABLE}, 32'h0);
    chk("setup_ready",   {31'h0, bus.ready}, 32'h0);
    chk("setup_paddr",   {28'h0, bus.PADDR}, {28'h0, a[3:0]});
    chk("setup_pwrite",  {31'h0, bus.PWRITE}, {31'h0, wr});
    chk("setup_pwdata",  bus.PWDATA, d);

    for (int i = 0; i <= ns; i++) begin
      @(negedge PCLK);  // ACCESS
      if (i == ns) stall = 1'b0;
      #1;
      chk("acc_psel",    {28'h0, psel_vec()}, {28'h0, exp_sel});
      chk("acc_penable", {31'h0, bus.PENABLE}, 32'h1);
      chk("acc_paddr",   {28'h0, bus.PADDR}, {28'h0, a[3:0]});
      chk("acc_pwrite",  {31'h0, bus.PWRITE}, {31'h0, wr});
      chk("acc_pwdata",  bus.PWDATA, d);
      chk("acc_ready",   {31'h0, bus.ready}, {31'h0, (i == ns)});
      chk("acc_rdata",   bus.rdata, exp_rd);
      if (i == ns) rd = bus.rdata;
    end
    if (wr && !err) mem[s][r] = d;

    @(negedge PCLK);  // back in IDLE
    bus.transfer = 1'b0;
  endtask

  logic [31:0] dir_addr [4];
  logic [31:0] dir_data [4];

  initial begin
    logic [31:0] rd;
    dir_addr = '{32'h1000_0000, 32'h1000_1000, 32'h1000_2000, 32'h1000_3000};
    dir_data = '{32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_BABE, 32'h8765_4321};
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 4; r++) mem[k][r] = 32'h0;

    PRESET       = 1'b1;
    stall        = 1'b0;
    bus.transfer = 1'b0;
    bus.write    = 1'b0;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
    repeat (3) @(negedge PCLK);
    chk_idle("rst");
    PRESET = 1'b0;
    @(negedge PCLK);

    // Directed writes then reads across all four slaves.
    for (int i = 0; i < 4; i++) xfer(1'b1, dir_addr[i], dir_data[i], 0, rd);
    chk_regs("dirw");
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, dir_addr[i], 32'h0, 0, rd);
      chk($sformatf("dir_rd%0d", i), rd, dir_data[i]);
    end

    // Two wait states on a write and on a read.
    xfer(1'b1, 32'h1000_1008, 32'hA5A5_0F0F, 2, rd);
    xfer(1'b0, 32'h1000_1008, 32'h0, 2, rd);
    chk("stall_rd", rd, 32'hA5A5_0F0F);

    // Reset in the middle of a stalled ACCESS.
    chk_idle("pre_abort");
    bus.transfer = 1'b1;
    bus.write    = 1'b1;
    bus.addr     = 32'h1000_2004;
    bus.wdata    = 32'h0BAD_F00D;
    @(negedge PCLK);
    bus.transfer = 1'b0;
    stall        = 1'b1;
    @(negedge PCLK);
    chk("abort_penable", {31'h0, bus.PENABLE}, 32'h1);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk_idle("abort");
    PRESET = 1'b0;
    stall  = 1'b0;
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 4; r++) mem[k][r] = 32'h0;
    chk_regs("abort");
    @(negedge PCLK);

`ifdef APB_ADDR_CHECK_EN
    xfer(1'b1, 32'h1000_0004, 32'h1111_2222, 0, rd);
    xfer(1'b1, 32'h2000_0000, 32'h5555_AAAA, 0, rd);
    xfer(1'b0, 32'h2000_0000, 32'h0, 0, rd);
    chk("oow_rd", rd, 32'h0);
    chk_regs("oow");
`endif

    // Randomized traffic; a quarter of requests use a random upper address.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] hi, a;
      hi = ($urandom_range(0, 3) == 0) ? $urandom : 32'h1000_0000;
      a  = {hi[31:14], 2'($urandom_range(0, 3)), 12'($urandom)};
      xfer(1'($urandom), a, $urandom, $urandom_range(0, 2), rd);
    end
    chk_regs("rand");
    chk_idle("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
